// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM.
// Optional immediate logic ops are enabled by CONTROL_IMM_LOGIC_EN.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_IMMEXEC  = 4'd9,
    S_IMMWB    = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  typedef struct packed {
    logic       pc_en;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic [2:0] alu_op;
    logic       alu_src;
    logic       illegal;
  } ctrl_t;

  function automatic logic is_imm_op(input logic [5:0] op);
`ifdef CONTROL_IMM_LOGIC_EN
    return (op == OP_ADDI) || (op == OP_ANDI) ||
           (op == OP_ORI)  || (op == OP_SLTI);
`else
    return (op == OP_ADDI);
`endif
  endfunction

`ifdef CONTROL_IMM_LOGIC_EN
  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      OP_SLTI: return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction
`endif

endpackage

// File: rtl/multicycle_control_ctrl_output_decode.sv
// Control output decode for the multicycle FSM.
// Immediate ALUOp selection depends on CONTROL_IMM_LOGIC_EN.
module ctrl_output_decode
  import mips_ctrl_pkg::*;
(
  input  state_e      state,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output ctrl_t       ctrl
);

  // Moore outputs per state; PCEn/IRWrite Mealy in FETCH/BRANCH
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read = 1'b1;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_en    = 1'b1;
          ctrl.pc_src   = PC_SEQ;
        end
      end
      S_MEMADR: begin
        ctrl.alu_op  = ALU_ADD;
        ctrl.alu_src = 1'b1;
      end
      S_MEMREAD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        ctrl.alu_src  = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_op = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_BRANCH: begin
        ctrl.alu_op = ALU_SUB;
        ctrl.pc_src = PC_BR;
        ctrl.pc_en  = (opcode == OP_BNE) ? ~zero : zero;
      end
      S_IMMEXEC, S_IMMWB: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = (state == S_IMMWB);
`ifdef CONTROL_IMM_LOGIC_EN
        ctrl.alu_op    = imm_alu_op(opcode);
`else
        ctrl.alu_op    = ALU_ADD;
`endif
      end
      S_JUMP: begin
        ctrl.pc_en  = 1'b1;
        ctrl.pc_src = PC_JMP;
      end
      S_TRAP: begin
        ctrl.illegal = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: state register and next-state logic.
// Define CONTROL_IMM_LOGIC_EN to accept andi/ori/slti.
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCEn,
  output logic [1:0] PCSrc,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic [2:0] ALUOp,
  output logic       ALUSrc,
  output logic [3:0] state,
  output logic       Illegal
);

  state_e state_q, state_d;
  ctrl_t  dec, ctrl;

  // Next-state sequencing through the instruction phases
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (opcode == OP_RTYPE)
          state_d = S_EXECUTE;
        else if (opcode == OP_LW || opcode == OP_SW)
          state_d = S_MEMADR;
        else if (opcode == OP_BEQ || opcode == OP_BNE)
          state_d = S_BRANCH;
        else if (is_imm_op(opcode))
          state_d = S_IMMEXEC;
        else if (opcode == OP_J)
          state_d = S_JUMP;
        else
          state_d = S_TRAP;
      end
      S_MEMADR:   state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_IMMEXEC:  state_d = S_IMMWB;
      S_IMMWB:    state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_TRAP;
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  ctrl_output_decode u_dec (
    .state     (state_q),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ctrl      (dec)
  );

  // Outputs forced quiet while reset is held
  always_comb begin
    ctrl = reset_n ? dec : '0;
  end

  assign PCEn     = ctrl.pc_en;
  assign PCSrc    = ctrl.pc_src;
  assign IorD     = ctrl.iord;
  assign MemRead  = ctrl.mem_read;
  assign MemWrite = ctrl.mem_write;
  assign IRWrite  = ctrl.ir_write;
  assign RegDst   = ctrl.reg_dst;
  assign MemtoReg = ctrl.mem_to_reg;
  assign RegWrite = ctrl.reg_write;
  assign ALUOp    = ctrl.alu_op;
  assign ALUSrc   = ctrl.alu_src;
  assign Illegal  = ctrl.illegal;
  assign state    = reset_n ? state_q : 4'd0;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with a scoreboard queue.
// Honours CONTROL_IMM_LOGIC_EN for the andi checks.
module tb_multicycle_control;

  logic       clock;
  logic       reset_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       PCEn;
  logic [1:0] PCSrc;
  logic       IorD, MemRead, MemWrite, IRWrite;
  logic       RegDst, MemtoReg, RegWrite;
  logic [2:0] ALUOp;
  logic       ALUSrc;
  logic [3:0] state;
  logic       Illegal;

  typedef struct packed {
    logic [3:0] st;
    logic       pcen;
    logic [1:0] pcsrc;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       rdst;
    logic       m2r;
    logic       rw;
    logic [2:0] aop;
    logic       asrc;
    logic       ill;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [5:0] R    = 6'b000000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] BNE  = 6'b000101;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] J    = 6'b000010;
  localparam logic [5:0] ANDI = 6'b001100;

  multicycle_control dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .PCEn      (PCEn),
    .PCSrc     (PCSrc),
    .IorD      (IorD),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .RegDst    (RegDst),
    .MemtoReg  (MemtoReg),
    .RegWrite  (RegWrite),
    .ALUOp     (ALUOp),
    .ALUSrc    (ALUSrc),
    .state     (state),
    .Illegal   (Illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [2:0] imm_op(input logic [5:0] op);
    case (op)
      6'b001100: return 3'b011;
      6'b001101: return 3'b100;
      6'b001010: return 3'b101;
      default:   return 3'b000;
    endcase
  endfunction

  // Expected outputs for a given state from the state table
  function automatic exp_t model(input logic [3:0] st,
                                 input logic [5:0] op,
                                 input logic z,
                                 input logic mr,
                                 input logic rn);
    exp_t e;
    e = '0;
    if (!rn) return e;
    e.st = st;
    case (st)
      4'd0: begin
        e.mrd = 1'b1;
        e.irw = mr;
        e.pcen = mr;
      end
      4'd2: e.asrc = 1'b1;
      4'd3: begin e.mrd = 1'b1; e.iord = 1'b1; e.asrc = 1'b1; end
      4'd4: begin e.rw = 1'b1; e.m2r = 1'b1; end
      4'd5: begin e.mwr = 1'b1; e.iord = 1'b1; e.asrc = 1'b1; end
      4'd6: e.aop = 3'b010;
      4'd7: begin e.rw = 1'b1; e.rdst = 1'b1; e.aop = 3'b010; end
      4'd8: begin
        e.aop = 3'b001;
        e.pcsrc = 2'b01;
        e.pcen = (op == BNE) ? !z : z;
      end
      4'd9: begin e.asrc = 1'b1; e.aop = imm_op(op); end
      4'd10: begin
        e.asrc = 1'b1;
        e.rw = 1'b1;
        e.aop = imm_op(op);
      end
      4'd11: begin e.pcen = 1'b1; e.pcsrc = 2'b10; end
      4'd12: e.ill = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  task automatic cyc(input logic [3:0] st, input logic [5:0] op,
                     input logic z, input logic mr, input logic rn,
                     input string tag);
    exp_t got, exp;
    opcode    = op;
    zero      = z;
    mem_ready = mr;
    reset_n   = rn;
    sb.push_back(model(st, op, z, mr, rn));
    #1;
    got = {state, PCEn, PCSrc, IorD, MemRead, MemWrite, IRWrite,
           RegDst, MemtoReg, RegWrite, ALUOp, ALUSrc, Illegal};
    exp = sb.pop_front();
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
    @(negedge clock);
  endtask

  initial begin
    reset_n   = 1'b0;
    opcode    = R;
    zero      = 1'b0;
    mem_ready = 1'b1;
    @(negedge clock);

    cyc(4'd0, R, 0, 1, 0, "rst0");
    cyc(4'd0, R, 0, 1, 0, "rst1");
    cyc(4'd0, R, 0, 1, 0, "rst2");

    cyc(4'd0, R, 0, 1, 1, "r_fetch");
    cyc(4'd1, R, 0, 1, 1, "r_decode");
    cyc(4'd6, R, 0, 1, 1, "r_exec");
    cyc(4'd7, R, 0, 1, 1, "r_aluwb");

    cyc(4'd0, LW, 0, 1, 1, "lw_fetch");
    cyc(4'd1, LW, 0, 1, 1, "lw_decode");
    cyc(4'd2, LW, 0, 1, 1, "lw_memadr");
    cyc(4'd3, LW, 0, 0, 1, "lw_wait0");
    cyc(4'd3, LW, 0, 0, 1, "lw_wait1");
    cyc(4'd3, LW, 0, 1, 1, "lw_memrd");
    cyc(4'd4, LW, 0, 0, 1, "lw_memwb");

    cyc(4'd0, BEQ, 1, 1, 1, "beq_fetch");
    cyc(4'd1, BEQ, 1, 1, 1, "beq_decode");
    cyc(4'd8, BEQ, 1, 1, 1, "beq_taken");
    cyc(4'd0, BNE, 1, 1, 1, "bne_fetch");
    cyc(4'd1, BNE, 1, 1, 1, "bne_decode");
    cyc(4'd8, BNE, 1, 1, 1, "bne_nottaken");
    cyc(4'd0, BNE, 0, 1, 1, "bne2_fetch");
    cyc(4'd1, BNE, 0, 1, 1, "bne2_decode");
    cyc(4'd8, BNE, 0, 0, 1, "bne_taken");

    cyc(4'd0, SW, 0, 1, 1, "sw_fetch");
    cyc(4'd1, SW, 0, 1, 1, "sw_decode");
    cyc(4'd2, SW, 0, 1, 1, "sw_memadr");
    cyc(4'd5, SW, 0, 1, 1, "sw_memwr");

    cyc(4'd0, ADDI, 0, 1, 1, "addi_fetch");
    cyc(4'd1, ADDI, 0, 1, 1, "addi_decode");
    cyc(4'd9, ADDI, 0, 1, 1, "addi_exec");
    cyc(4'd10, ADDI, 0, 1, 1, "addi_wb");

    cyc(4'd0, J, 0, 0, 1, "j_fetch_stall");
    cyc(4'd0, J, 0, 1, 1, "j_fetch");
    cyc(4'd1, J, 0, 1, 1, "j_decode");
    cyc(4'd11, J, 0, 1, 1, "j_jump");

    cyc(4'd0, ANDI, 0, 1, 1, "andi_fetch");
    cyc(4'd1, ANDI, 0, 1, 1, "andi_decode");
`ifdef CONTROL_IMM_LOGIC_EN
    cyc(4'd9, ANDI, 0, 1, 1, "andi_exec");
    cyc(4'd10, ANDI, 0, 1, 1, "andi_wb");
`else
    cyc(4'd12, ANDI, 0, 1, 1, "trap0");
    cyc(4'd12, R, 0, 0, 1, "trap_sticky1");
    cyc(4'd12, J, 1, 1, 1, "trap_sticky2");
    cyc(4'd12, R, 0, 1, 0, "trap_reset");
`endif

    cyc(4'd0, SW, 0, 1, 1, "sw2_fetch");
    cyc(4'd1, SW, 0, 1, 1, "sw2_decode");
    cyc(4'd2, SW, 0, 1, 1, "sw2_memadr");
    cyc(4'd5, SW, 0, 0, 1, "sw2_wait");
    cyc(4'd5, SW, 0, 0, 0, "sw2_reset");
    cyc(4'd0, R, 0, 0, 1, "post_reset_fetch");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
